// File: rtl/cp0_regfile_v2_if.sv
// Bus between the memory/writeback stage and the CP0 register file.
// No valid/ready pairs here: we, exc_valid and eret are single-cycle commit strobes sampled on every non-stalled edge; stall holds all state.
interface cp0_regfile_v2_if #(
  parameter int DATA_W     = 32,
  parameter int NUM_HW_INT = 6
);
  logic                  stall;
  logic                  we;
  logic [4:0]            waddr;
  logic [4:0]            raddr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;
  logic [NUM_HW_INT-1:0] hw_int;
  logic                  exc_valid;
  logic [4:0]            exc_code;
  logic [DATA_W-1:0]     exc_pc;
  logic                  exc_in_ds;
  logic [DATA_W-1:0]     exc_badvaddr;
  logic                  eret;
  logic                  int_pending;
  logic                  flush;
  logic [DATA_W-1:0]     redirect_pc;
  logic [DATA_W-1:0]     status_o;
  logic [DATA_W-1:0]     cause_o;
  logic [DATA_W-1:0]     epc_o;

  modport slave (
    input  stall, we, waddr, raddr, wdata, hw_int,
    input  exc_valid, exc_code, exc_pc, exc_in_ds, exc_badvaddr, eret,
    output rdata, int_pending, flush, redirect_pc, status_o, cause_o, epc_o
  );

  modport master (
    output stall, we, waddr, raddr, wdata, hw_int,
    output exc_valid, exc_code, exc_pc, exc_in_ds, exc_badvaddr, eret,
    input  rdata, int_pending, flush, redirect_pc, status_o, cause_o, epc_o
  );
endinterface

// File: rtl/cp0_regfile_v2.sv
// Second-generation CP0: timer, interrupt masking, exception/ERET commit and
// a registered flush/redirect toward fetch.
module cp0_regfile_v2 #(
  parameter int                DATA_W     = 32,
  parameter int                NUM_HW_INT = 6,
  parameter logic [DATA_W-1:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [DATA_W-1:0] PRID_VAL   = 32'h004C0102,
  parameter logic [DATA_W-1:0] CONFIG_VAL = 32'h00008000,
  parameter bit                TIMER_EN   = 1'b1
) (
  input logic             clk,
  input logic             rst,
  cp0_regfile_v2_if.slave bus
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  localparam logic [DATA_W-1:0] STATUS_RST = 32'h1000_0000;

  typedef enum logic [1:0] {
    CMT_IDLE,
    CMT_MTC0,
    CMT_ERET,
    CMT_EXC
  } commit_e;

  commit_e commit;

  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] compare_q, compare_d;
  logic [DATA_W-1:0] status_q, status_d;
  logic [DATA_W-1:0] epc_q, epc_d;
  logic [DATA_W-1:0] badvaddr_q, badvaddr_d;
  logic [DATA_W-1:0] redirect_q, redirect_d;
  logic              bd_q, bd_d;
  logic              ti_q, ti_d;
  logic              iv_q, iv_d;
  logic [1:0]        ip_sw_q, ip_sw_d;
  logic [5:0]        hw_q, hw_d;
  logic [4:0]        exc_code_q, exc_code_d;
  logic              flush_q, flush_d;
  logic              int_pending_q, int_pending_d;

  logic [5:0]        hw_ext;
  logic [7:0]        ip_q, ip_d;
  logic [DATA_W-1:0] cause_q;
  logic              timer_match;

  // Unused hardware lines stay zero so IP7 reduces to TI alone.
  always_comb begin
    hw_ext = '0;
    hw_ext[NUM_HW_INT-1:0] = bus.hw_int;
  end

  always_comb begin
    ip_q = {hw_q[5] | ti_q, hw_q[4:0], ip_sw_q};
    ip_d = {hw_d[5] | ti_d, hw_d[4:0], ip_sw_d};
  end

  assign cause_q = {bd_q, ti_q, 6'b0, iv_q, 7'b0, ip_q, 1'b0, exc_code_q, 2'b0};

  assign timer_match = TIMER_EN && (compare_q != '0) && (count_q == compare_q);

  always_comb begin
    commit = CMT_IDLE;
    if (bus.exc_valid) begin
      commit = CMT_EXC;
    end else if (bus.eret) begin
      commit = CMT_ERET;
    end else if (bus.we) begin
      commit = CMT_MTC0;
    end
  end

  always_comb begin
    count_d    = count_q + DATA_W'(1);
    compare_d  = compare_q;
    status_d   = status_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    redirect_d = redirect_q;
    bd_d       = bd_q;
    ti_d       = ti_q | timer_match;
    iv_d       = iv_q;
    ip_sw_d    = ip_sw_q;
    hw_d       = hw_ext;
    exc_code_d = exc_code_q;
    flush_d    = 1'b0;

    unique case (commit)
      CMT_EXC: begin
        // A nested exception keeps the original return point.
        if (!status_q[1]) begin
          epc_d = bus.exc_in_ds ? bus.exc_pc - DATA_W'(4) : bus.exc_pc;
          bd_d  = bus.exc_in_ds;
        end
        status_d[1] = 1'b1;
        exc_code_d  = bus.exc_code;
        if (bus.exc_code == 5'd4 || bus.exc_code == 5'd5) begin
          badvaddr_d = bus.exc_badvaddr;
        end
        flush_d    = 1'b1;
        redirect_d = EXC_VECTOR;
      end
      CMT_ERET: begin
        status_d[1] = 1'b0;
        flush_d     = 1'b1;
        redirect_d  = epc_q;
      end
      CMT_MTC0: begin
        unique case (bus.waddr)
          REG_COUNT:   count_d = bus.wdata;
          REG_COMPARE: begin
            compare_d = bus.wdata;
            ti_d      = 1'b0;
          end
          REG_STATUS:  status_d = bus.wdata;
          REG_CAUSE: begin
            ip_sw_d = bus.wdata[9:8];
            iv_d    = bus.wdata[23];
          end
          REG_EPC:     epc_d = bus.wdata;
          default:     ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    int_pending_d = status_d[0] & ~status_d[1] & (|(ip_d & status_d[15:8]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q       <= '0;
      compare_q     <= '0;
      status_q      <= STATUS_RST;
      epc_q         <= '0;
      badvaddr_q    <= '0;
      redirect_q    <= '0;
      bd_q          <= 1'b0;
      ti_q          <= 1'b0;
      iv_q          <= 1'b0;
      ip_sw_q       <= '0;
      hw_q          <= '0;
      exc_code_q    <= '0;
      flush_q       <= 1'b0;
      int_pending_q <= 1'b0;
    end else if (bus.stall) begin
      flush_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      compare_q     <= compare_d;
      status_q      <= status_d;
      epc_q         <= epc_d;
      badvaddr_q    <= badvaddr_d;
      redirect_q    <= redirect_d;
      bd_q          <= bd_d;
      ti_q          <= ti_d;
      iv_q          <= iv_d;
      ip_sw_q       <= ip_sw_d;
      hw_q          <= hw_d;
      exc_code_q    <= exc_code_d;
      flush_q       <= flush_d;
      int_pending_q <= int_pending_d;
    end
  end

  always_comb begin
    unique case (bus.raddr)
      REG_BADVADDR: bus.rdata = badvaddr_q;
      REG_COUNT:    bus.rdata = count_q;
      REG_COMPARE:  bus.rdata = compare_q;
      REG_STATUS:   bus.rdata = status_q;
      REG_CAUSE:    bus.rdata = cause_q;
      REG_EPC:      bus.rdata = epc_q;
      REG_PRID:     bus.rdata = PRID_VAL;
      REG_CONFIG:   bus.rdata = CONFIG_VAL;
      default:      bus.rdata = '0;
    endcase
  end

  assign bus.int_pending = int_pending_q;
  assign bus.flush       = flush_q;
  assign bus.redirect_pc = redirect_q;
  assign bus.status_o    = status_q;
  assign bus.cause_o     = cause_q;
  assign bus.epc_o       = epc_q;

endmodule

// File: tb/tb_cp0_regfile_v2.sv
// Bench for cp0_regfile_v2: directed scenarios plus a randomized run against
// a word-level reference model of the CP0 rules.
module tb_cp0_regfile_v2;
  localparam int          DATA_W     = 32;
  localparam int          NUM_HW_INT = 6;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;
  localparam logic [31:0] PRID_VAL   = 32'h004C0102;
  localparam logic [31:0] CONFIG_VAL = 32'h00008000;
  localparam bit          TIMER_EN   = 1'b1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cp0_regfile_v2_if #(.DATA_W(DATA_W), .NUM_HW_INT(NUM_HW_INT)) bus();

  cp0_regfile_v2 #(
    .DATA_W(DATA_W), .NUM_HW_INT(NUM_HW_INT), .EXC_VECTOR(EXC_VECTOR),
    .PRID_VAL(PRID_VAL), .CONFIG_VAL(CONFIG_VAL), .TIMER_EN(TIMER_EN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc, m_bad, m_redirect;
  logic        m_int, m_flush;
  logic [31:0] exp_q[$];

  task automatic model_reset();
    m_count = 0; m_compare = 0; m_status = 32'h1000_0000; m_cause = 0;
    m_epc = 0; m_bad = 0; m_redirect = 0; m_int = 0; m_flush = 0;
  endtask

  task automatic model_step();
    logic [31:0] cnt, cmp, s, c, e;
    logic ti;
    if (bus.stall) begin
      m_flush = 1'b0;
      return;
    end
    cnt = m_count + 1; cmp = m_compare; s = m_status; c = m_cause; e = m_epc;
    ti = m_cause[30];
    if (TIMER_EN && m_compare != 0 && m_count == m_compare) ti = 1'b1;
    m_flush = 1'b0;
    if (bus.exc_valid) begin
      if (!m_status[1]) begin
        e = bus.exc_in_ds ? bus.exc_pc - 32'd4 : bus.exc_pc;
        c[31] = bus.exc_in_ds;
      end
      s[1] = 1'b1;
      c[6:2] = bus.exc_code;
      if (bus.exc_code == 5'd4 || bus.exc_code == 5'd5) m_bad = bus.exc_badvaddr;
      m_flush = 1'b1; m_redirect = EXC_VECTOR;
    end else if (bus.eret) begin
      s[1] = 1'b0;
      m_flush = 1'b1; m_redirect = m_epc;
    end else if (bus.we) begin
      case (bus.waddr)
        5'd9:  cnt = bus.wdata;
        5'd11: begin cmp = bus.wdata; ti = 1'b0; end
        5'd12: s = bus.wdata;
        5'd13: c = (c & ~32'h0080_0300) | (bus.wdata & 32'h0080_0300);
        5'd14: e = bus.wdata;
        default: ;
      endcase
    end
    c[15:10] = 6'b0;
    for (int i = 0; i < NUM_HW_INT; i++) c[10+i] = bus.hw_int[i];
    c[15] = c[15] | ti;
    c[30] = ti;
    m_int = s[0] & ~s[1] & (|(c[15:8] & s[15:8]));
    m_count = cnt; m_compare = cmp; m_status = s; m_cause = c; m_epc = e;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_bad;
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return PRID_VAL;
      5'd16: return CONFIG_VAL;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.stall = 0; bus.we = 0; bus.waddr = 0; bus.wdata = 0;
    bus.exc_valid = 0; bus.exc_code = 0; bus.exc_pc = 0; bus.exc_in_ds = 0;
    bus.exc_badvaddr = 0; bus.eret = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we = 1; bus.waddr = a; bus.wdata = d;
    tick();
    bus.we = 0;
  endtask

  task automatic do_reset();
    idle();
    bus.hw_int = 0;
    rst = 1;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    bus.hw_int = 6'b000001;
    mtc0(5'd9, 32'h50);
    repeat (5) tick();
    bus.raddr = 5'd9; #1;
    checks++; if (bus.rdata !== 32'h55) begin errors++; $display("FAIL pre_reset_count: got %h expected %h", bus.rdata, 32'h55); end
    checks++; if (bus.cause_o[10] !== 1'b1) begin errors++; $display("FAIL pre_reset_ip2: got %b expected 1", bus.cause_o[10]); end
    #2;
    rst = 1; model_reset(); #1;
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", bus.rdata); end
    checks++; if (bus.cause_o !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h expected 0", bus.cause_o); end
    checks++; if (bus.flush !== 1'b0 || bus.int_pending !== 1'b0) begin errors++; $display("FAIL reset_flush_int: got %b%b expected 00", bus.flush, bus.int_pending); end
    bus.raddr = 5'd12; #1;
    checks++; if (bus.rdata !== 32'h1000_0000) begin errors++; $display("FAIL reset_status: got %h expected 10000000", bus.rdata); end
    bus.raddr = 5'd15; #1;
    checks++; if (bus.rdata !== PRID_VAL) begin errors++; $display("FAIL reset_prid: got %h expected %h", bus.rdata, PRID_VAL); end
    bus.raddr = 5'd20; #1;
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", bus.rdata); end
    bus.hw_int = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_timer();
    do_reset();
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    bus.raddr = 5'd9;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (bus.rdata !== 32'(i) || bus.cause_o[30] !== 1'b0) begin errors++; $display("FAIL timer_run: got count %h ti %b expected count %h ti 0", bus.rdata, bus.cause_o[30], i); end
      tick();
    end
    checks++; if (bus.cause_o[30] !== 1'b1 || bus.cause_o[15] !== 1'b1) begin errors++; $display("FAIL timer_ti_set: got ti %b ip7 %b expected 1 1", bus.cause_o[30], bus.cause_o[15]); end
    repeat (3) tick();
    checks++; if (bus.cause_o[30] !== 1'b1) begin errors++; $display("FAIL timer_ti_sticky: got %b expected 1", bus.cause_o[30]); end
    mtc0(5'd11, 32'd9);
    bus.raddr = 5'd11; #1;
    checks++; if (bus.cause_o[30] !== 1'b0 || bus.rdata !== 32'd9) begin errors++; $display("FAIL timer_clear: got ti %b compare %h expected 0 9", bus.cause_o[30], bus.rdata); end
    // Compare write in the very cycle Count equals the old Compare.
    mtc0(5'd11, 32'd30);
    mtc0(5'd9, 32'd29);
    tick();
    mtc0(5'd11, 32'd40);
    checks++; if (bus.cause_o[30] !== 1'b0 || bus.cause_o !== m_cause) begin errors++; $display("FAIL timer_write_wins: got %h expected %h", bus.cause_o, m_cause); end
  endtask

  task automatic test_interrupt();
    do_reset();
    bus.hw_int = 6'b000001;
    mtc0(5'd12, 32'h0000_0401);
    checks++; if (bus.cause_o[10] !== 1'b1 || bus.int_pending !== 1'b1) begin errors++; $display("FAIL irq_take: got ip2 %b pend %b expected 1 1", bus.cause_o[10], bus.int_pending); end
    mtc0(5'd12, 32'h0000_0403);
    checks++; if (bus.int_pending !== 1'b0) begin errors++; $display("FAIL irq_exl_mask: got %b expected 0", bus.int_pending); end
    mtc0(5'd12, 32'h0000_0801);
    checks++; if (bus.int_pending !== 1'b0) begin errors++; $display("FAIL irq_im_mask: got %b expected 0", bus.int_pending); end
    bus.hw_int = 6'b000010;
    tick();
    checks++; if (bus.int_pending !== 1'b1 || bus.cause_o[11] !== 1'b1) begin errors++; $display("FAIL irq_ip3: got pend %b ip3 %b expected 1 1", bus.int_pending, bus.cause_o[11]); end
    mtc0(5'd13, 32'hFFFF_FFFF);
    checks++; if (bus.cause_o !== 32'h0080_0B00) begin errors++; $display("FAIL cause_write_mask: got %h expected 00800b00", bus.cause_o); end
    bus.hw_int = 0;
  endtask

  task automatic test_exception();
    do_reset();
    bus.exc_valid = 1; bus.exc_code = 5'd4; bus.exc_pc = 32'h8000_1004;
    bus.exc_in_ds = 1; bus.exc_badvaddr = 32'h3;
    tick();
    idle();
    bus.raddr = 5'd8; #1;
    checks++; if (bus.epc_o !== 32'h8000_1000) begin errors++; $display("FAIL exc_epc: got %h expected 80001000", bus.epc_o); end
    checks++; if (bus.cause_o[31] !== 1'b1 || bus.cause_o[6:2] !== 5'd4 || bus.status_o[1] !== 1'b1) begin errors++; $display("FAIL exc_cause: got cause %h status %h expected bd 1 code 4 exl 1", bus.cause_o, bus.status_o); end
    checks++; if (bus.rdata !== 32'h3) begin errors++; $display("FAIL exc_badvaddr: got %h expected 3", bus.rdata); end
    checks++; if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'hBFC0_0380) begin errors++; $display("FAIL exc_redirect: got flush %b pc %h expected 1 bfc00380", bus.flush, bus.redirect_pc); end
    tick();
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL exc_flush_pulse: got %b expected 0", bus.flush); end
  endtask

  task automatic test_nested_eret();
    bus.exc_valid = 1; bus.exc_code = 5'd8; bus.exc_pc = 32'h8000_2000;
    bus.exc_in_ds = 0; bus.exc_badvaddr = 32'h1234;
    tick();
    idle();
    bus.raddr = 5'd8; #1;
    checks++; if (bus.epc_o !== 32'h8000_1000 || bus.cause_o[31] !== 1'b1) begin errors++; $display("FAIL nested_epc: got epc %h bd %b expected 80001000 1", bus.epc_o, bus.cause_o[31]); end
    checks++; if (bus.rdata !== 32'h3 || bus.cause_o[6:2] !== 5'd8) begin errors++; $display("FAIL nested_code: got bad %h code %0d expected 3 8", bus.rdata, bus.cause_o[6:2]); end
    bus.eret = 1; bus.we = 1; bus.waddr = 5'd14; bus.wdata = 32'hFFFF;
    tick();
    idle();
    checks++; if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h8000_1000) begin errors++; $display("FAIL eret_redirect: got flush %b pc %h expected 1 80001000", bus.flush, bus.redirect_pc); end
    checks++; if (bus.status_o[1] !== 1'b0 || bus.epc_o !== 32'h8000_1000) begin errors++; $display("FAIL eret_state: got exl %b epc %h expected 0 80001000", bus.status_o[1], bus.epc_o); end
  endtask

  task automatic test_stall_priority();
    do_reset();
    mtc0(5'd9, 32'd100);
    bus.raddr = 5'd9;
    bus.stall = 1; bus.exc_valid = 1; bus.exc_code = 5'd8; bus.exc_pc = 32'h8000_3000;
    bus.we = 1; bus.waddr = 5'd14; bus.wdata = 32'hDEAD;
    repeat (3) begin
      tick(); #1;
      checks++; if (bus.epc_o !== 32'h0 || bus.flush !== 1'b0 || bus.rdata !== 32'd100 || bus.status_o !== 32'h1000_0000) begin errors++; $display("FAIL stall_hold: got epc %h flush %b count %h status %h expected 0 0 64 10000000", bus.epc_o, bus.flush, bus.rdata, bus.status_o); end
    end
    bus.stall = 0;
    tick();
    idle(); #1;
    checks++; if (bus.epc_o !== 32'h8000_3000 || bus.cause_o[6:2] !== 5'd8 || bus.flush !== 1'b1) begin errors++; $display("FAIL stall_release: got epc %h code %0d flush %b expected 80003000 8 1", bus.epc_o, bus.cause_o[6:2], bus.flush); end
    checks++; if (bus.rdata !== 32'd101) begin errors++; $display("FAIL stall_count: got %h expected 65", bus.rdata); end
  endtask

  task automatic test_wrap();
    do_reset();
    mtc0(5'd9, 32'hFFFF_FFFE);
    bus.raddr = 5'd9; #1;
    checks++; if (bus.rdata !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_load: got %h expected fffffffe", bus.rdata); end
    tick(); tick(); #1;
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL wrap_count: got %h expected 0", bus.rdata); end
    bus.exc_valid = 1; bus.exc_code = 5'd10; bus.exc_pc = 32'h0; bus.exc_in_ds = 1;
    tick();
    idle();
    checks++; if (bus.epc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_epc: got %h expected fffffffc", bus.epc_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mtc0(5'd14, 32'h8000_4000);
    exp_q.push_back(EXC_VECTOR);
    exp_q.push_back(32'h8000_5000);
    bus.exc_valid = 1; bus.exc_code = 5'd12; bus.exc_pc = 32'h8000_5000;
    tick();
    idle();
    bus.eret = 1;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) tick();
      checks++; if (bus.flush !== 1'b1 || bus.redirect_pc !== exp_q[0]) begin errors++; $display("FAIL b2b_redirect: got flush %b pc %h expected 1 %h", bus.flush, bus.redirect_pc, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    idle();
    tick();
    checks++; if (bus.flush !== 1'b0 || bus.status_o[1] !== 1'b0) begin errors++; $display("FAIL b2b_settle: got flush %b exl %b expected 0 0", bus.flush, bus.status_o[1]); end
  endtask

  task automatic test_random();
    logic [4:0] waddrs [8];
    logic [4:0] codes   [8];
    waddrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd8, 5'd15, 5'd3};
    codes  = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12, 5'd13};
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bus.stall        = ($urandom_range(0, 7) == 0);
      bus.we           = ($urandom_range(0, 2) == 0);
      bus.waddr        = waddrs[$urandom_range(0, 7)];
      bus.wdata        = $urandom;
      if (bus.waddr == 5'd11) bus.wdata = m_count + 32'($urandom_range(0, 6));
      if (bus.waddr == 5'd12) bus.wdata = $urandom & 32'hFFFF_FF01;
      bus.exc_valid    = ($urandom_range(0, 15) == 0);
      bus.exc_code     = codes[$urandom_range(0, 7)];
      bus.exc_pc       = $urandom;
      bus.exc_in_ds    = 1'($urandom);
      bus.exc_badvaddr = $urandom;
      bus.eret         = ($urandom_range(0, 11) == 0);
      bus.hw_int       = NUM_HW_INT'($urandom);
      bus.raddr        = 5'($urandom_range(7, 17));
      tick();
      checks++; if (bus.rdata !== model_read(bus.raddr)) begin errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", bus.raddr, bus.rdata, model_read(bus.raddr)); end
      checks++; if (bus.status_o !== m_status || bus.cause_o !== m_cause || bus.epc_o !== m_epc) begin errors++; $display("FAIL rand_regs: got %h %h %h expected %h %h %h", bus.status_o, bus.cause_o, bus.epc_o, m_status, m_cause, m_epc); end
      checks++; if (bus.int_pending !== m_int || bus.flush !== m_flush) begin errors++; $display("FAIL rand_ctl: got pend %b flush %b expected %b %b", bus.int_pending, bus.flush, m_int, m_flush); end
      if (m_flush) begin
        checks++; if (bus.redirect_pc !== m_redirect) begin errors++; $display("FAIL rand_redirect: got %h expected %h", bus.redirect_pc, m_redirect); end
      end
    end
    idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    idle();
    bus.hw_int = 0;
    bus.raddr  = 0;
    rst = 1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    test_reset();
    test_timer();
    test_interrupt();
    test_exception();
    test_nested_eret();
    test_stall_priority();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_regfile_v2.md
Name: cp0_regfile_v2

Overview:
Parametrised second-generation coprocessor-0 block for the MIPS pipeline, used at the memory/writeback boundary. It holds Count, Compare, Status, Cause, EPC, BadVAddr, PRId and Config. It adds three things over the first generation:
- an internal interrupt-pending decision (IE/EXL/IM masking);
- a registered exception/ERET redirect output with a configurable vector;
- a configurable number of hardware interrupt lines, with the timer folded into IP7.

Parameters:
- DATA_W, 32, register width (only 32 is legal; kept for lint uniformity).
- NUM_HW_INT, 6, hardware interrupt lines mapped to Cause.IP[2+NUM_HW_INT-1:2]; legal range 1..6.
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception.
- PRID_VAL, 32'h004C0102, PRId constant.
- CONFIG_VAL, 32'h00008000, Config constant.
- TIMER_EN, 1, when 0 the Compare match never raises Cause.TI.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- stall  in  1  freezes all state updates except reset
- we  in  1  MTC0 write enable
- waddr  in  5  MTC0 register number
- raddr  in  5  MFC0 register number
- wdata  in  DATA_W  MTC0 data
- rdata  out  DATA_W  MFC0 data (combinational)
- hw_int  in  NUM_HW_INT  level-sensitive external interrupts
- exc_valid  in  1  exception commits this cycle
- exc_code  in  5  ExcCode (0 = Int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, 10 RI, 12 Ov, 13 Tr)
- exc_pc  in  DATA_W  PC of the faulting instruction
- exc_in_ds  in  1  faulting instruction is in a delay slot
- exc_badvaddr  in  DATA_W  faulting address (AdEL/AdES)
- eret  in  1  ERET commits this cycle
- int_pending  out  1  interrupt should be taken at the next commit
- flush  out  1  pipeline flush pulse
- redirect_pc  out  DATA_W  fetch target qualified by flush
- status_o, cause_o, epc_o  out  DATA_W  live register copies

Behaviour:
- Reset (async, immediate):
  - Count = 0, Compare = 0, Status = 32'h1000_0000, Cause = 0, EPC = 0, BadVAddr = 0.
  - flush = 0, redirect_pc = 0, int_pending = 0.
- stall = 1: no register changes, flush forced 0 next edge. rdata still reflects current values.
- Count increments by 1 each non-stalled cycle and wraps 32'hFFFFFFFF -> 0. An MTC0 to Count (reg 9) overrides the increment that cycle.
- Timer:
  - When TIMER_EN = 1, Compare != 0 and Count == Compare, Cause.TI (bit 30) is set on that edge and stays set.
  - An MTC0 to Compare (reg 11) clears TI and loads Compare. This wins over a match in the same cycle.
- Cause.IP:
  - Cause.IP[2+NUM_HW_INT-1:2] is sampled from hw_int every non-stalled cycle. Unused hardware IP bits read 0.
  - Cause.IP7 = hw_int[5] (if present) OR TI.
  - Cause.IP[1:0] are software bits, written by MTC0 to Cause (reg 13) together with IV (23). No other Cause bits are writable.
- MTC0 Status (reg 12) writes all bits. EPC (reg 14) writes all bits. BadVAddr, PRId, Config are read-only.
- int_pending (registered) = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[15:8]), evaluated from next-state values.
- Exception commit (exc_valid = 1), on the same edge:
  - Status.EXL = 1 and Cause.ExcCode = exc_code.
  - If Status.EXL was already 1, EPC and BD are left unchanged.
  - Otherwise EPC = exc_in_ds ? exc_pc - 4 : exc_pc, and Cause.BD = exc_in_ds.
  - BadVAddr = exc_badvaddr for codes 4 and 5 only.
  - flush = 1 and redirect_pc = EXC_VECTOR for exactly one cycle after the edge.
- ERET (eret = 1, exc_valid = 0): Status.EXL = 0, flush = 1, redirect_pc = EPC (the value before any same-cycle write).
- Priority within one non-stalled cycle:
  - exc_valid > eret > MTC0.
  - An MTC0 is dropped entirely when exc_valid or eret is asserted.
  - Count increment and IP sampling always occur.
- MFC0 reads regs 8, 9, 11, 12, 13, 14, 15 (PRId), 16 (Config). Any other address returns 0. No write-to-read bypass.
- Register-file arithmetic is modulo 2^32. The exc_pc - 4 wrap at 0 is allowed.

Test Plan:
- Reset asserted mid-run with Count = 32'h55 -> Count, Cause, flush immediately 0; Status reads 32'h10000000; PRId reads 32'h004C0102.
- MTC0 Compare = 5, then Count runs 0..5 -> Cause[30] = 1 on the edge after Count = 5. MTC0 Compare = 9 -> Cause[30] = 0 the next cycle.
- Status = 32'h0000_0401, hw_int[0] = 1 -> Cause[10] = 1, int_pending = 1. Set Status.EXL -> int_pending = 0.
- exc_valid, code 4, exc_pc = 32'h80001004, exc_in_ds = 1, badvaddr = 32'h3 -> EPC = 32'h80001000, Cause[31] = 1, Cause[6:2] = 4, BadVAddr = 3, flush one cycle with redirect_pc = 32'hBFC00380.
- Nested exception with EXL = 1, exc_pc = 32'h80002000 -> EPC unchanged. ERET -> flush with redirect_pc = old EPC, EXL = 0.
- Same cycle: exc_valid (code 8) + MTC0 EPC = 32'hDEAD + stall toggled -> while stalled, nothing changes. When released, the exception wins, EPC = exc_pc, and the MTC0 is discarded.
